// File: rtl/bottle_seq_ctrl.sv
// -----------------------------------------------------------------------------
// bottle_seq_ctrl
//   Pill-bottling sequencer. Counts pills into the current bottle up to a BCD
//   target, then runs the conveyor to change bottles, and stops with all_full
//   once the BCD bottles-per-batch target has been reached.
//
//   Optional build macro: CONV_DELAY_EN
//     undefined : the bottle change (CHANGE) lasts a single cycle.
//     defined   : CHANGE lasts 8 cycles, timed by an internal 3-bit counter.
//
// Ports
//   CLK                 in   rising-edge clock
//   RST                 in   synchronous active-high reset
//   start               in   level, begin / resume a batch
//   pause               in   level, hold filling
//   set_mode            in   level, enter configuration mode
//   key_load            in   pulse, latch the four target digits (in SETUP)
//   pillL_in/pillH_in   in   BCD pills-per-bottle target (units/tens)
//   botL_in/botH_in     in   BCD bottles-per-batch target (units/tens)
//   pill_in             in   pulse per detected pill
//   pillL/pillH         out  BCD pills in the current bottle
//   botL/botH           out  BCD completed bottles
//   valve_open          out  high while filling
//   conveyor_run        out  high while changing bottles
//   all_full            out  high when the batch is complete
//   cfg_err             out  latched targets are invalid (non-BCD or 00)
//   state               out  current FSM state (IDLE=0 .. FULL=5)
//   bottle_done         out  one-cycle pulse per completed bottle
// -----------------------------------------------------------------------------
module bottle_seq_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       pause,
  input  logic       set_mode,
  input  logic       key_load,
  input  logic [3:0] pillL_in,
  input  logic [3:0] pillH_in,
  input  logic [3:0] botL_in,
  input  logic [3:0] botH_in,
  input  logic       pill_in,
  output logic [3:0] pillL,
  output logic [3:0] pillH,
  output logic [3:0] botL,
  output logic [3:0] botH,
  output logic       valve_open,
  output logic       conveyor_run,
  output logic       all_full,
  output logic       cfg_err,
  output logic [2:0] state,
  output logic       bottle_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    FILL   = 3'd2,
    CHANGE = 3'd3,
    PAUSE  = 3'd4,
    FULL   = 3'd5
  } state_t;

  state_t     st;
  logic [3:0] tgt_pill_l;
  logic [3:0] tgt_pill_h;
  logic [3:0] tgt_bot_l;
  logic [3:0] tgt_bot_h;
  logic       chg_last;   // current CHANGE cycle is the last one

  // Two-digit BCD increment that holds at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)
      r = v;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Moore outputs for a state: {valve_open, conveyor_run, all_full}.
  // Loaded together with the state so they are registered and glitch-free.
  function automatic logic [2:0] outs_for(input state_t s);
    return {s == FILL, s == CHANGE, s == FULL};
  endfunction

  // A target set is bad if any digit is non-BCD or either target is 00.
  function automatic logic cfg_bad(input logic [3:0] pl, input logic [3:0] ph,
                                   input logic [3:0] bl, input logic [3:0] bh);
    return (pl > 4'd9) || (ph > 4'd9) || (bl > 4'd9) || (bh > 4'd9) ||
           ({ph, pl} == 8'h00) || ({bh, bl} == 8'h00);
  endfunction

`ifdef CONV_DELAY_EN
  logic [2:0] conv_tmr;

  // Runs only while in CHANGE, so it is always 0 on entry.
  always_ff @(posedge CLK) begin
    if (RST || st != CHANGE)
      conv_tmr <= 3'd0;
    else
      conv_tmr <= conv_tmr + 3'd1;
  end

  assign chg_last = (conv_tmr == 3'd7);
`else
  assign chg_last = 1'b1;
`endif

  assign state = st;

  always_ff @(posedge CLK) begin
    if (RST) begin
      st           <= IDLE;
      pillL        <= 4'd0;
      pillH        <= 4'd0;
      botL         <= 4'd0;
      botH         <= 4'd0;
      tgt_pill_l   <= 4'd0;
      tgt_pill_h   <= 4'd0;
      tgt_bot_l    <= 4'd0;
      tgt_bot_h    <= 4'd0;
      cfg_err      <= 1'b1;
      valve_open   <= 1'b0;
      conveyor_run <= 1'b0;
      all_full     <= 1'b0;
      bottle_done  <= 1'b0;
    end else begin
      bottle_done <= 1'b0;
      case (st)
        IDLE: begin
          if (set_mode) begin
            st <= SETUP;
            {valve_open, conveyor_run, all_full} <= outs_for(SETUP);
          end else if (start && !cfg_err) begin
            st <= FILL;
            {valve_open, conveyor_run, all_full} <= outs_for(FILL);
          end
        end

        SETUP: begin
          if (key_load) begin
            tgt_pill_l <= pillL_in;
            tgt_pill_h <= pillH_in;
            tgt_bot_l  <= botL_in;
            tgt_bot_h  <= botH_in;
            cfg_err    <= cfg_bad(pillL_in, pillH_in, botL_in, botH_in);
          end
          if (!set_mode) begin
            st <= IDLE;
            {valve_open, conveyor_run, all_full} <= outs_for(IDLE);
          end
        end

        FILL: begin
          if (pill_in) begin
            {pillH, pillL} <= bcd_inc({pillH, pillL});
            // The completing pill wins over pause.
            if (bcd_inc({pillH, pillL}) == {tgt_pill_h, tgt_pill_l}) begin
              st           <= CHANGE;
              {botH, botL} <= bcd_inc({botH, botL});
              bottle_done  <= 1'b1;
              {valve_open, conveyor_run, all_full} <= outs_for(CHANGE);
            end else if (pause) begin
              st <= PAUSE;
              {valve_open, conveyor_run, all_full} <= outs_for(PAUSE);
            end
          end else if (pause) begin
            st <= PAUSE;
            {valve_open, conveyor_run, all_full} <= outs_for(PAUSE);
          end
        end

        PAUSE: begin
          if (!pause) begin
            st <= FILL;
            {valve_open, conveyor_run, all_full} <= outs_for(FILL);
          end
        end

        CHANGE: begin
          if (chg_last) begin
            pillL <= 4'd0;
            pillH <= 4'd0;
            if ({botH, botL} == {tgt_bot_h, tgt_bot_l}) begin
              st <= FULL;
              {valve_open, conveyor_run, all_full} <= outs_for(FULL);
            end else begin
              st <= FILL;
              {valve_open, conveyor_run, all_full} <= outs_for(FILL);
            end
          end
        end

        FULL: begin
          // Leaving FULL either way starts the next batch from zero.
          if (set_mode) begin
            st    <= SETUP;
            pillL <= 4'd0;
            pillH <= 4'd0;
            botL  <= 4'd0;
            botH  <= 4'd0;
            {valve_open, conveyor_run, all_full} <= outs_for(SETUP);
          end else if (start) begin
            st    <= FILL;
            pillL <= 4'd0;
            pillH <= 4'd0;
            botL  <= 4'd0;
            botH  <= 4'd0;
            {valve_open, conveyor_run, all_full} <= outs_for(FILL);
          end
        end

        default: begin
          st <= IDLE;
          {valve_open, conveyor_run, all_full} <= outs_for(IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bottle_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bottle_seq_ctrl
//   Directed scenarios followed by randomized stimulus, every cycle compared
//   against an integer-level behavioural model of the bottling sequencer.
// -----------------------------------------------------------------------------
module tb_bottle_seq_ctrl;

`ifdef CONV_DELAY_EN
  localparam int CHG_LEN = 8;
`else
  localparam int CHG_LEN = 1;
`endif

  localparam int S_IDLE = 0, S_SETUP = 1, S_FILL = 2, S_CHANGE = 3,
                 S_PAUSE = 4, S_FULL = 5;

  // ---------------- clock / reset ----------------
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0, pause = 1'b0, set_mode = 1'b0, key_load = 1'b0;
  logic [3:0] pillL_in = 4'd0, pillH_in = 4'd0, botL_in = 4'd0, botH_in = 4'd0;
  logic       pill_in = 1'b0;
  logic [3:0] pillL, pillH, botL, botH;
  logic       valve_open, conveyor_run, all_full, cfg_err, bottle_done;
  logic [2:0] state;

  always #5 CLK = ~CLK;

  bottle_seq_ctrl dut (
    .CLK(CLK), .RST(RST), .start(start), .pause(pause), .set_mode(set_mode),
    .key_load(key_load), .pillL_in(pillL_in), .pillH_in(pillH_in),
    .botL_in(botL_in), .botH_in(botH_in), .pill_in(pill_in),
    .pillL(pillL), .pillH(pillH), .botL(botL), .botH(botH),
    .valve_open(valve_open), .conveyor_run(conveyor_run), .all_full(all_full),
    .cfg_err(cfg_err), .state(state), .bottle_done(bottle_done)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_done_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_st = S_IDLE;
  int m_pills = 0, m_bots = 0;
  int m_tpl = 0, m_tph = 0, m_tbl = 0, m_tbh = 0;
  int m_err = 1;
  int m_done = 0;
  int m_chg = 0;   // cycles spent in the current bottle change

  function automatic int bad_cfg(input int pl, input int ph, input int bl,
                                 input int bh);
    return (pl > 9 || ph > 9 || bl > 9 || bh > 9 ||
            (ph * 10 + pl) == 0 || (bh * 10 + bl) == 0) ? 1 : 0;
  endfunction

  task automatic model_step();
    if (RST) begin
      m_st = S_IDLE; m_pills = 0; m_bots = 0;
      m_tpl = 0; m_tph = 0; m_tbl = 0; m_tbh = 0;
      m_err = 1; m_done = 0; m_chg = 0;
    end else begin
      m_done = 0;
      case (m_st)
        S_IDLE: begin
          if (set_mode) m_st = S_SETUP;
          else if (start && m_err == 0) m_st = S_FILL;
        end
        S_SETUP: begin
          if (key_load) begin
            m_tpl = pillL_in; m_tph = pillH_in; m_tbl = botL_in; m_tbh = botH_in;
            m_err = bad_cfg(m_tpl, m_tph, m_tbl, m_tbh);
          end
          if (!set_mode) m_st = S_IDLE;
        end
        S_FILL: begin
          if (pill_in) begin
            if (m_pills < 99) m_pills++;
            if (m_pills == m_tph * 10 + m_tpl) begin
              m_st = S_CHANGE;
              if (m_bots < 99) m_bots++;
              m_done = 1;
              m_chg = 0;
            end else if (pause) m_st = S_PAUSE;
          end else if (pause) m_st = S_PAUSE;
        end
        S_PAUSE: if (!pause) m_st = S_FILL;
        S_CHANGE: begin
          m_chg++;
          if (m_chg == CHG_LEN) begin
            m_pills = 0;
            m_st = (m_bots == m_tbh * 10 + m_tbl) ? S_FULL : S_FILL;
          end
        end
        S_FULL: begin
          if (set_mode) begin m_st = S_SETUP; m_pills = 0; m_bots = 0; end
          else if (start) begin m_st = S_FILL; m_pills = 0; m_bots = 0; end
        end
        default: m_st = S_IDLE;
      endcase
    end
  endtask

  task automatic compare_all();
    check("state", 32'(state), 32'(m_st));
    check("pillL", 32'(pillL), 32'(m_pills % 10));
    check("pillH", 32'(pillH), 32'(m_pills / 10));
    check("botL", 32'(botL), 32'(m_bots % 10));
    check("botH", 32'(botH), 32'(m_bots / 10));
    check("valve_open", 32'(valve_open), 32'(m_st == S_FILL));
    check("conveyor_run", 32'(conveyor_run), 32'(m_st == S_CHANGE));
    check("all_full", 32'(all_full), 32'(m_st == S_FULL));
    check("cfg_err", 32'(cfg_err), 32'(m_err));
    check("bottle_done", 32'(bottle_done), 32'(m_done));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    compare_all();
    if (bottle_done === 1'b1) n_done_seen++;
  endtask

  task automatic do_reset();
    RST = 1'b1; tick(); RST = 1'b0;
  endtask

  task automatic load_targets(input logic [3:0] pl, input logic [3:0] ph,
                              input logic [3:0] bl, input logic [3:0] bh);
    set_mode = 1'b1; tick();
    key_load = 1'b1;
    pillL_in = pl; pillH_in = ph; botL_in = bl; botH_in = bh;
    tick();
    key_load = 1'b0; set_mode = 1'b0; tick();
  endtask

  task automatic start_batch();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pill_pulse();
    pill_in = 1'b1; tick(); pill_in = 1'b0;
  endtask

  // Ticks while the conveyor runs; returns how many cycles it was high.
  task automatic run_change(output int n);
    n = 0;
    for (int i = 0; i < 20 && conveyor_run === 1'b1; i++) begin
      n++; tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_conv;
    do_reset();
    check("rst_state", 32'(state), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd1);

    // Pill 03 / bottle 02: one bottle, then the batch.
    load_targets(4'd3, 4'd0, 4'd2, 4'd0);
    check("cfg_ok", 32'(cfg_err), 32'd0);
    start_batch();
    n_done_seen = 0;
    pill_pulse(); tick(); pill_pulse(); tick(); pill_pulse();
    check("b1_done", 32'(bottle_done), 32'd1);
    check("b1_botL", 32'(botL), 32'd1);
    check("b1_state", 32'(state), 32'(S_CHANGE));
    run_change(n_conv);
    check("conv_len_1", 32'(n_conv), 32'(CHG_LEN));
    check("b1_pill_clr", 32'(pillL), 32'd0);
    check("b1_refill", 32'(state), 32'(S_FILL));
    check("b1_done_once", 32'(n_done_seen), 32'd1);
    pill_pulse(); pill_pulse(); pill_pulse();
    run_change(n_conv);
    check("conv_len_2", 32'(n_conv), 32'(CHG_LEN));
    check("full_flag", 32'(all_full), 32'd1);
    check("full_state", 32'(state), 32'(S_FULL));
    check("full_bot", 32'({botH, botL}), 32'h02);
    check("full_valve", 32'(valve_open), 32'd0);
    start_batch();
    check("restart_bot", 32'({botH, botL}), 32'h00);
    check("restart_state", 32'(state), 32'(S_FILL));

    // Reset during a bottle change.
    pill_pulse(); pill_pulse(); pill_pulse();
    check("chg_before_rst", 32'(state), 32'(S_CHANGE));
    RST = 1'b1; tick(); RST = 1'b0;
    check("rst_chg_state", 32'(state), 32'd0);
    check("rst_chg_counts", 32'({botH, botL, pillH, pillL}), 32'd0);
    check("rst_chg_conv", 32'(conveyor_run), 32'd0);

    // Non-BCD target blocks start.
    load_targets(4'hA, 4'd0, 4'd2, 4'd0);
    check("bad_cfg", 32'(cfg_err), 32'd1);
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bad_cfg_idle", 32'(state), 32'(S_IDLE));
    end
    start = 1'b0;

    // Pill target 12: BCD carry, then pause ignoring pills.
    load_targets(4'd2, 4'd1, 4'd2, 4'd0);
    start_batch();
    for (int i = 0; i < 10; i++) begin pill_pulse(); tick(); end
    check("carry_count", 32'({pillH, pillL}), 32'h10);
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pill_in = (i == 1 || i == 3); tick();
    end
    pill_in = 1'b0;
    check("pause_count", 32'({pillH, pillL}), 32'h10);
    check("pause_state", 32'(state), 32'(S_PAUSE));
    check("pause_valve", 32'(valve_open), 32'd0);
    pause = 1'b0; tick();
    check("resume_state", 32'(state), 32'(S_FILL));
    pause = 1'b1; pill_in = 1'b1; tick(); pill_in = 1'b0;
    check("pill_and_pause", 32'({pillH, pillL}), 32'h11);
    check("pill_and_pause_st", 32'(state), 32'(S_PAUSE));
    pause = 1'b0; tick();

    // Randomized phase.
    for (int c = 0; c < 3000; c++) begin
      RST      = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) set_mode = ~set_mode;
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      start    = ($urandom_range(0, 5) == 0);
      pill_in  = ($urandom_range(0, 1) == 1);
      key_load = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) begin
        pillL_in = 4'($urandom_range(0, 15));
        pillH_in = 4'($urandom_range(0, 15));
        botL_in  = 4'($urandom_range(0, 15));
        botH_in  = 4'($urandom_range(0, 15));
      end else begin
        pillL_in = 4'($urandom_range(0, 5));
        pillH_in = 4'($urandom_range(0, 1));
        botL_in  = 4'($urandom_range(0, 3));
        botH_in  = 4'd0;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bottle_seq_ctrl.md
BOTTLE_SEQ_CTRL -- requirements
Module: bottle_seq_ctrl

Interface
REQ-001 SHALL have port CLK  input  1  single rising-edge system clock.
REQ-002 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port start  input  1  level; begins or resumes a batch.
REQ-004 SHALL have port pause  input  1  level; holds filling while high.
REQ-005 SHALL have port set_mode  input  1  level; selects configuration mode.
REQ-006 SHALL have port key_load  input  1  one-cycle pulse; latches the four target digits.
REQ-007 SHALL have ports pillL_in/pillH_in  input  4 each  BCD pills-per-bottle target (units/tens).
REQ-008 SHALL have ports botL_in/botH_in  input  4 each  BCD bottles-per-batch target (units/tens).
REQ-009 SHALL have port pill_in  input  1  one-cycle pulse per pill detected by the sensor.
REQ-010 SHALL have ports pillL/pillH  output  4 each  BCD pills in the current bottle.
REQ-011 SHALL have ports botL/botH  output  4 each  BCD completed bottles.
REQ-012 SHALL have outputs valve_open, conveyor_run, all_full, cfg_err (1 each), and state (3).
REQ-013 SHALL have output bottle_done  1  one-cycle pulse on each completed bottle.

Function
REQ-014 SHALL implement states IDLE=0, SETUP=1, FILL=2, CHANGE=3, PAUSE=4, FULL=5; state output reflects the current state.
REQ-015 IDLE: set_mode=1 -> SETUP; else start=1 and cfg_err=0 -> FILL; start ignored while cfg_err=1.
REQ-016 SETUP: key_load latches the targets; set_mode=0 -> IDLE; set_mode takes priority over start in IDLE and FULL.
REQ-017 cfg_err SHALL be 1 when any latched digit exceeds 9 or either latched target equals 00; updated in the cycle after key_load.
REQ-018 FILL: valve_open=1; each pill_in increments the pill count in BCD (units 9 -> 0 with tens carry), registered next cycle.
REQ-019 FILL: when a pill_in makes the pill count equal the pill target, the next state SHALL be CHANGE; the bottle count increments BCD and bottle_done pulses in that same transition.
REQ-020 FILL: pause=1 with no completing pill -> PAUSE; pill_in and pause in the same cycle -> pill counted, then pause.
REQ-021 PAUSE: valve_open=0; pill_in ignored; pause=0 -> FILL, with counts unchanged.
REQ-022 CHANGE: valve_open=0, conveyor_run=1, pill_in ignored; on exit, pill count clears to 00.
REQ-023 CHANGE exit: if the bottle count equals the bottle target -> FULL, else -> FILL; pause is ignored during CHANGE.
REQ-024 FULL: all_full=1, valve_open=0; start=1 -> clear both counts, clear all_full, and go to FILL.
REQ-025 Counts SHALL never exceed 99; targets are compared digit-wise.
REQ-026 All outputs SHALL be registered; there are no combinational input-to-output paths.

Reset
REQ-027 RST=1 at a clock edge SHALL force IDLE and clear pill and bottle counts to 00.
REQ-028 RST SHALL clear valve_open, conveyor_run, all_full and bottle_done to 0; state reads 0.
REQ-029 RST SHALL set the latched targets to 00, so cfg_err=1 after reset.
REQ-030 RST mid-operation (any state) SHALL take effect at that edge and override all other inputs.

Configuration
REQ-031 Macro CONV_DELAY_EN: when defined, CHANGE SHALL last exactly 8 cycles, counted by an internal 3-bit timer.
REQ-032 When CONV_DELAY_EN is undefined, CHANGE SHALL last exactly 1 cycle and no timer is built.

Verification
REQ-033 Reset, load pill 03 / bottle 02, start, 3 pill_in pulses -> bottle_done once, botL=1, pillL returns to 0 after CHANGE.
REQ-034 Same targets, 6 pill_in pulses total -> all_full=1, state=5, botH:botL=02, valve_open=0.
REQ-035 Load pill 0A -> cfg_err=1; start held 5 cycles -> state stays IDLE.
REQ-036 Pill target 12, 10 pulses -> pillH:pillL=10 (BCD carry); pause held 4 cycles with 2 pill_in pulses -> count stays 10.
REQ-037 With CONV_DELAY_EN defined, complete a bottle -> conveyor_run high exactly 8 cycles; undefined -> high exactly 1 cycle.
REQ-038 RST asserted during CHANGE -> next cycle state=0, counts 00, conveyor_run=0.
